// File: rtl/gate_tb_pkg.sv
// Shared types and reference truth tables for the basic-gate stimulus/response stages.
// Truth tables are indexed by the input vector {in[N_IN-1..0]}.
package gate_tb_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0] NOR_TT  = 4'b0001;
  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] XOR_TT  = 4'b0110;

endpackage

// File: rtl/settle_timer.sv
// Settle-time counter: clear wins over enable; expired flags the last hold cycle.
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [TW-1:0] count;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TW'(1);
    end
  end

  assign expired = (count == TW'(SETTLE - 1));

endmodule

// File: rtl/gate_truth_table_sequencer.sv
// Sweeps every input vector onto a gate under test, samples its output after a
// settle time and scores it against the EXPECT truth table.
module gate_truth_table_sequencer #(
  parameter int                  N_IN   = 2,
  parameter logic [2**N_IN-1:0]  EXPECT = gate_tb_pkg::NOR_TT,
  parameter int                  SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_y,
  output logic [N_IN-1:0] drv,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_idx
);

  // Imported in the body so the SETTLE parameter shadows the enum literal;
  // the state of that name is always written gate_tb_pkg::SETTLE.
  import gate_tb_pkg::*;

  localparam logic [N_IN-1:0] LAST_IDX = '1;

  state_t          state, state_next;
  logic [N_IN-1:0] idx;
  logic            accept, last, mismatch;
  logic            timer_clr, timer_en, timer_expired;
  logic [N_IN:0]   err_next;

  assign accept    = start && (state == IDLE || state == DONE);
  assign last      = (idx == LAST_IDX);
  // Case inequality so an X or Z from the gate scores as a mismatch.
  assign mismatch  = (dut_y !== EXPECT[idx]);
  assign err_next  = err_count + (N_IN + 1)'(mismatch);
  assign timer_clr = accept || (state == CHECK);
  assign timer_en  = (state == gate_tb_pkg::SETTLE) && !timer_expired;

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: default assigned first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE:          if (start) state_next = gate_tb_pkg::SETTLE;
      gate_tb_pkg::SETTLE: if (timer_expired) state_next = CHECK;
      CHECK:               state_next = last ? DONE : gate_tb_pkg::SETTLE;
      default:             state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
      pass       <= 1'b0;
    end else if (accept) begin
      idx        <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
      pass       <= 1'b0;
    end else if (state == CHECK) begin
      err_count <= err_next;
      if (mismatch && !fail_valid) begin
        fail_valid <= 1'b1;
        fail_idx   <= idx;
      end
      if (last) pass <= (err_next == '0);
      else      idx  <= idx + N_IN'(1);
    end
  end

  // The driven vector is the sweep index, so it holds its last value in DONE.
  assign drv  = idx;
  assign busy = (state == gate_tb_pkg::SETTLE) || (state == CHECK);
  assign done = (state == DONE);

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Directed bench: default NOR sequencer with selectable gate models, plus an
// AND-table instance and a 3-input SETTLE=1 instance.
module tb_gate_truth_table_sequencer;
  import gate_tb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] starts = '0;
  int         mode = 0;
  logic       x_val;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  // Instance 0: defaults (N_IN=2, NOR, SETTLE=2)
  logic       y0, busy0, done0, pass0, fv0;
  logic [1:0] drv0, fidx0;
  logic [2:0] err0;

  always_comb begin
    case (mode)
      1:       y0 = 1'b0;
      2:       y0 = &drv0;
      3:       y0 = (drv0 == 2'd3) ? x_val : ~|drv0;
      default: y0 = ~|drv0;
    endcase
  end

  gate_truth_table_sequencer dut0 (
    .clk(clk), .rst(rst), .start(starts[0]), .dut_y(y0), .drv(drv0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .fail_idx(fidx0)
  );

  // Instance 1: AND table with an AND model
  logic       y1, busy1, done1, pass1, fv1;
  logic [1:0] drv1, fidx1;
  logic [2:0] err1;
  assign y1 = &drv1;

  gate_truth_table_sequencer #(.EXPECT(AND_TT)) dut1 (
    .clk(clk), .rst(rst), .start(starts[1]), .dut_y(y1), .drv(drv1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_idx(fidx1)
  );

  // Instance 2: 3-input NOR, SETTLE=1
  logic       y2, busy2, done2, pass2, fv2;
  logic [2:0] drv2, fidx2;
  logic [3:0] err2;
  assign y2 = ~|drv2;

  gate_truth_table_sequencer #(.N_IN(3), .EXPECT(8'h01), .SETTLE(1)) dut2 (
    .clk(clk), .rst(rst), .start(starts[2]), .dut_y(y2), .drv(drv2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fv2), .fail_idx(fidx2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Start is high across exactly one rising edge ("edge 0"); returns at the next falling edge.
  task automatic pulse(input int which);
    @(negedge clk);
    starts[which] = 1'b1;
    @(negedge clk);
    starts[which] = 1'b0;
  endtask

  task automatic wait_done0(input int budget);
    int n = 0;
    while (!done0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("done0_within_budget", 32'(done0), 32'd1);
  endtask

  initial begin
    x_val = 1'bx;
    // Two-state simulators cannot hold X; a forced wrong level stands in for it.
    if (x_val === 1'b0 || x_val === 1'b1) x_val = 1'b1;

    // Reset state
    #2;
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_drv", 32'(drv0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);
    check("rst_state", 32'(dut0.state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    // 1: golden NOR, drv stepping and done at edge 12
    mode = 0;
    pulse(0);
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      if (e % 3 == 1) check($sformatf("t1_drv_e%0d", e), 32'(drv0), 32'((e - 1) / 3));
      if (e == 11) check("t1_done_e11", 32'(done0), 32'd0);
      if (e == 12) check("t1_done_e12", 32'(done0), 32'd1);
    end
    check("t1_pass", 32'(pass0), 32'd1);
    check("t1_err", 32'(err0), 32'd0);
    check("t1_fv", 32'(fv0), 32'd0);
    check("t1_busy", 32'(busy0), 32'd0);

    // 2: output stuck at 0
    mode = 1;
    pulse(0);
    wait_done0(60);
    check("t2_err", 32'(err0), 32'd1);
    check("t2_fidx", 32'(fidx0), 32'd0);
    check("t2_fv", 32'(fv0), 32'd1);
    check("t2_pass", 32'(pass0), 32'd0);

    // 3: AND gate against the NOR table, then against the AND table
    mode = 2;
    pulse(0);
    wait_done0(60);
    check("t3_err", 32'(err0), 32'd2);
    check("t3_fidx", 32'(fidx0), 32'd0);
    check("t3_pass", 32'(pass0), 32'd0);
    pulse(1);
    repeat (12) @(posedge clk);
    #1;
    check("t3_and_done", 32'(done1), 32'd1);
    check("t3_and_pass", 32'(pass1), 32'd1);
    check("t3_and_err", 32'(err1), 32'd0);

    // 4: start while busy ignored, start in DONE restarts
    mode = 0;
    pulse(0);
    repeat (2) @(negedge clk);
    starts[0] = 1'b1;
    @(negedge clk);
    starts[0] = 1'b0;
    repeat (3) @(negedge clk);
    starts[0] = 1'b1;
    @(negedge clk);
    starts[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t4_done_e11", 32'(done0), 32'd0);
    @(posedge clk);
    #1;
    check("t4_done_e12", 32'(done0), 32'd1);
    check("t4_pass", 32'(pass0), 32'd1);
    check("t4_drv_hold", 32'(drv0), 32'd3);
    @(negedge clk);
    starts[0] = 1'b1;
    @(posedge clk);
    #1;
    check("t4_restart_done", 32'(done0), 32'd0);
    check("t4_restart_busy", 32'(busy0), 32'd1);
    check("t4_restart_drv", 32'(drv0), 32'd0);
    @(negedge clk);
    starts[0] = 1'b0;
    wait_done0(60);
    check("t4_rerun_pass", 32'(pass0), 32'd1);

    // 5: asynchronous reset during vector 2
    mode = 1;
    pulse(0);
    repeat (7) @(posedge clk);
    #1;
    check("t5_pre_drv", 32'(drv0), 32'd2);
    check("t5_pre_err", 32'(err0), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_busy", 32'(busy0), 32'd0);
    check("t5_rst_drv", 32'(drv0), 32'd0);
    check("t5_rst_err", 32'(err0), 32'd0);
    check("t5_rst_fv", 32'(fv0), 32'd0);
    check("t5_rst_state", 32'(dut0.state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    mode = 0;
    pulse(0);
    wait_done0(60);
    check("t5_after_pass", 32'(pass0), 32'd1);
    check("t5_after_err", 32'(err0), 32'd0);

    // 6: unknown output on vector 3 only
    mode = 3;
    pulse(0);
    wait_done0(60);
    check("t6_err", 32'(err0), 32'd1);
    check("t6_fidx", 32'(fidx0), 32'd3);
    check("t6_fv", 32'(fv0), 32'd1);

    // 7: 3-input NOR, SETTLE=1
    pulse(2);
    repeat (15) @(posedge clk);
    #1;
    check("t7_done_e15", 32'(done2), 32'd0);
    @(posedge clk);
    #1;
    check("t7_done_e16", 32'(done2), 32'd1);
    check("t7_pass", 32'(pass2), 32'd1);
    check("t7_err", 32'(err2), 32'd0);
    check("t7_drv_last", 32'(drv2), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
